// File: rtl/regs_wb.sv
// regs_wb: writeback buffer in front of the 8x8 register file.
//
// Execute-stage results (one or two bytes per entry) are accepted over a
// valid/ready handshake, queued in a DEPTH-entry FIFO and drained up to two
// entries per cycle onto the register file's four write lanes, which share a
// single write enable.
//
// Optional feature macro: REGS_WB_SCOREBOARD_EN
//   Adds pending[7:0] (registers with a buffered write) and in_wait (forces
//   in_ready low so issue logic can stall on read-after-write hazards).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      entry handshake
//   in_v0/in_a0/in_d0        byte 0 valid, register index, data
//   in_v1/in_a1/in_d1        byte 1 valid, register index, data
//   hold                     suppress draining this cycle
//   in_wait, pending         scoreboard feature only
//   wen                      register file write enable (all lanes)
//   waddr0..3, wdata0..3     write lanes; lane 3 wins on address collision
//   empty, count             FIFO occupancy
module regs_wb #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_v0,
    input  logic [2:0]       in_a0,
    input  logic [7:0]       in_d0,
    input  logic             in_v1,
    input  logic [2:0]       in_a1,
    input  logic [7:0]       in_d1,
    input  logic             hold,
`ifdef REGS_WB_SCOREBOARD_EN
    input  logic             in_wait,
    output logic [7:0]       pending,
`endif
    output logic             wen,
    output logic [2:0]       waddr0,
    output logic [2:0]       waddr1,
    output logic [2:0]       waddr2,
    output logic [2:0]       waddr3,
    output logic [7:0]       wdata0,
    output logic [7:0]       wdata1,
    output logic [7:0]       wdata2,
    output logic [7:0]       wdata3,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic       v0;
        logic [2:0] a0;
        logic [7:0] d0;
        logic       v1;
        logic [2:0] a1;
        logic [7:0] d1;
    } entry_t;

    entry_t           mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic             full;
    logic             accept;
    logic             store;
    logic [1:0]       drain_n;
    entry_t           ent_old;
    entry_t           ent_new;

    logic [3:0]       lane_v;
    logic [3:0][2:0]  lane_a;
    logic [3:0][7:0]  lane_d;
    logic [2:0]       hi_a;
    logic [7:0]       hi_d;
    logic [3:0][2:0]  out_a;
    logic [3:0][7:0]  out_d;

    // ------------------------------------------------------------------
    // Handshake: ready depends only on the registered count, so a full
    // FIFO never accepts even when it is draining in the same cycle.
    // ------------------------------------------------------------------
    assign full = (count_reg == CNT_W'(DEPTH));
`ifdef REGS_WB_SCOREBOARD_EN
    assign in_ready = !full && !in_wait;
`else
    assign in_ready = !full;
`endif
    assign accept = in_valid && in_ready;
    // Entries with no valid byte complete the handshake but are dropped.
    assign store  = accept && (in_v0 || in_v1);

    always_comb begin
        drain_n = 2'd0;
        if (hold || (count_reg == '0)) begin
            drain_n = 2'd0;
        end else if (count_reg == CNT_W'(1)) begin
            drain_n = 2'd1;
        end else begin
            drain_n = 2'd2;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(store);
        rd_ptr_next = rd_ptr_reg + PTR_W'(drain_n);
        count_next  = count_reg + CNT_W'(store) - CNT_W'(drain_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (!rst && store) begin
            mem_reg[wr_ptr_reg] <= {in_v0, in_a0, in_d0, in_v1, in_a1, in_d1};
        end
    end

    assign count = count_reg;
    assign empty = (count_reg == '0);

    // ------------------------------------------------------------------
    // Lane mapping: oldest entry on lanes 0/1, second-oldest on lanes 2/3,
    // so a same-register collision resolves to the newest byte.
    // ------------------------------------------------------------------
    assign ent_old = mem_reg[rd_ptr_reg];
    assign ent_new = mem_reg[rd_ptr_reg + PTR_W'(1)];

    always_comb begin
        lane_v[0] = (drain_n != 2'd0) && ent_old.v0;
        lane_v[1] = (drain_n != 2'd0) && ent_old.v1;
        lane_v[2] = (drain_n == 2'd2) && ent_new.v0;
        lane_v[3] = (drain_n == 2'd2) && ent_new.v1;
        lane_a[0] = ent_old.a0;
        lane_a[1] = ent_old.a1;
        lane_a[2] = ent_new.a0;
        lane_a[3] = ent_new.a1;
        lane_d[0] = ent_old.d0;
        lane_d[1] = ent_old.d1;
        lane_d[2] = ent_new.d0;
        lane_d[3] = ent_new.d1;
        // Highest-numbered valid lane carries the newest value; idle lanes
        // copy it so the shared write enable cannot clobber anything.
        hi_a = 3'd0;
        hi_d = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (lane_v[i]) begin
                hi_a = lane_a[i];
                hi_d = lane_d[i];
            end
        end
    end

    assign wen = |lane_v;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign out_a[gi] = !wen ? 3'd0 : (lane_v[gi] ? lane_a[gi] : hi_a);
            assign out_d[gi] = !wen ? 8'd0 : (lane_v[gi] ? lane_d[gi] : hi_d);
        end
    endgenerate

    assign waddr0 = out_a[0];
    assign waddr1 = out_a[1];
    assign waddr2 = out_a[2];
    assign waddr3 = out_a[3];
    assign wdata0 = out_d[0];
    assign wdata1 = out_d[1];
    assign wdata2 = out_d[2];
    assign wdata3 = out_d[3];

`ifdef REGS_WB_SCOREBOARD_EN
    // ------------------------------------------------------------------
    // Pending map: a slot is live when its distance from the read pointer
    // is below the count; includes entries draining this cycle.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0][7:0] slot_pend;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
            logic [PTR_W-1:0] age;
            logic             occupied;
            assign age      = PTR_W'(gi) - rd_ptr_reg;
            assign occupied = (CNT_W'(age) < count_reg);
            assign slot_pend[gi] = occupied ?
                ((8'(mem_reg[gi].v0) << mem_reg[gi].a0) |
                 (8'(mem_reg[gi].v1) << mem_reg[gi].a1)) : 8'd0;
        end
    endgenerate

    always_comb begin
        pending = 8'd0;
        for (int i = 0; i < DEPTH; i++) begin
            pending = pending | slot_pend[i];
        end
    end
`endif

endmodule
